// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types for the two-requester memory arbiter: owner
//               identity and FSM state encodings, plus a small mapping helper.
// Revision    : 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

    // Who currently drives the memory port.
    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_CORE = 2'd1,
        OWNER_DBG  = 2'd2
    } owner_t;

    // Arbiter FSM: idle (arbitrating) or locked to one requester.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } state_t;

    // Lock state entered when a given owner is granted a multi-cycle transfer.
    function automatic state_t own_state(input owner_t owner);
        state_t st;
        case (owner)
            OWNER_CORE: st = OWN_CORE;
            OWNER_DBG:  st = OWN_DBG;
            default:    st = IDLE;
        endcase
        return st;
    endfunction

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_watchdog
// Description : Transfer watchdog. Counts cycles a granted transfer spends
//               waiting for memory and flags expiry on ownership cycle
//               TIMEOUT. The counter self-clears when it expires.
// Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int                 c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_count;

    // Expiry fires only while a transfer is still waiting this cycle.
    always_comb begin
        expire = run && (r_count == c_LAST);
    end

    // Cycle counter: restarts on clear or expiry, advances while waiting.
    always_ff @(posedge clk) begin
        if (rst || clear || expire) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : mem_arbiter_watchdog
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares a single memory port between the core control path
//               and the debug system-bus access. Zero-latency forwarding,
//               grant locked for the duration of a transfer, watchdog abort
//               of hung transfers with an error response.
//               Build option: define MEM_ARBITER_RR_EN for round-robin on
//               contention; otherwise debug has fixed priority.
// Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   core_addr,
    input  logic [DATA_WIDTH-1:0]   core_wdata,
    input  logic [DATA_WIDTH/8-1:0] core_be,
    input  logic                    core_read,
    input  logic                    core_write,
    output logic [DATA_WIDTH-1:0]   core_rdata,
    output logic                    core_complete,
    output logic                    core_error,

    input  logic [ADDR_WIDTH-1:0]   dbg_addr,
    input  logic [DATA_WIDTH-1:0]   dbg_wdata,
    input  logic [DATA_WIDTH/8-1:0] dbg_be,
    input  logic                    dbg_read,
    input  logic                    dbg_write,
    output logic [DATA_WIDTH-1:0]   dbg_rdata,
    output logic                    dbg_complete,
    output logic                    dbg_error,

    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic                    mem_read,
    output logic                    mem_write,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_complete
);

    import mem_arbiter_pkg::*;

    state_t r_state;
    state_t w_state_next;
    owner_t w_winner;
    owner_t w_owner;

    logic w_core_req;
    logic w_dbg_req;
    logic w_owner_req;
    logic w_wd_clear;
    logic w_wd_run;
    logic w_expire;
    logic w_done;

`ifdef MEM_ARBITER_RR_EN
    owner_t r_last_owner;
`endif

    // Request levels; a write with read also high still counts as one request.
    always_comb begin
        w_core_req = core_read | core_write;
        w_dbg_req  = dbg_read  | dbg_write;
    end

    // Combinational arbitration used while idle.
    always_comb begin
        w_winner = OWNER_NONE;
        if (w_core_req && w_dbg_req) begin
`ifdef MEM_ARBITER_RR_EN
            w_winner = (r_last_owner == OWNER_CORE) ? OWNER_DBG : OWNER_CORE;
`else
            w_winner = OWNER_DBG;
`endif
        end else if (w_core_req) begin
            w_winner = OWNER_CORE;
        end else if (w_dbg_req) begin
            w_winner = OWNER_DBG;
        end
    end

    // Current owner: arbitration result when idle, locked owner otherwise.
    always_comb begin
        case (r_state)
            IDLE:     w_owner = w_winner;
            OWN_CORE: w_owner = OWNER_CORE;
            OWN_DBG:  w_owner = OWNER_DBG;
            default:  w_owner = OWNER_NONE;
        endcase
    end

    // Transfer status: owner still requesting, watchdog control, completion.
    always_comb begin
        w_owner_req = ((w_owner == OWNER_CORE) && w_core_req) ||
                      ((w_owner == OWNER_DBG)  && w_dbg_req);
        w_wd_run    = w_owner_req && !mem_complete;
        w_wd_clear  = !w_owner_req || mem_complete;
        w_done      = w_owner_req && (mem_complete || w_expire);
    end

    mem_arbiter_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_wd_clear),
        .run    (w_wd_run),
        .expire (w_expire)
    );

    // Request/response mux; everything held at zero while in reset.
    always_comb begin
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_be        = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        core_rdata    = '0;
        core_complete = 1'b0;
        core_error    = 1'b0;
        dbg_rdata     = '0;
        dbg_complete  = 1'b0;
        dbg_error     = 1'b0;
        if (!rst) begin
            case (w_owner)
                OWNER_CORE: begin
                    mem_addr      = core_addr;
                    mem_wdata     = core_wdata;
                    mem_be        = core_be;
                    mem_read      = core_read && !core_write && !w_expire;
                    mem_write     = core_write && !w_expire;
                    core_rdata    = w_expire ? '0 : mem_rdata;
                    core_complete = w_done;
                    core_error    = w_expire;
                end
                OWNER_DBG: begin
                    mem_addr      = dbg_addr;
                    mem_wdata     = dbg_wdata;
                    mem_be        = dbg_be;
                    mem_read      = dbg_read && !dbg_write && !w_expire;
                    mem_write     = dbg_write && !w_expire;
                    dbg_rdata     = w_expire ? '0 : mem_rdata;
                    dbg_complete  = w_done;
                    dbg_error     = w_expire;
                end
                default: begin
                end
            endcase
        end
    end

    // Next state: lock on an unfinished grant, release on done or abort.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if ((w_winner != OWNER_NONE) && !w_done) begin
                    w_state_next = own_state(w_winner);
                end
            end
            OWN_CORE, OWN_DBG: begin
                if (!w_owner_req || w_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

`ifdef MEM_ARBITER_RR_EN
    // Remember who finished last so contention alternates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_owner <= OWNER_CORE;
        end else if (w_done) begin
            r_last_owner <= w_owner;
        end
    end
`endif

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Directed scenarios
//               followed by randomized traffic, all outputs compared each
//               cycle against a transaction-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int c_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic [3:0]  core_be;
    logic        core_read, core_write, core_complete, core_error;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [3:0]  dbg_be;
    logic        dbg_read, dbg_write, dbg_complete, dbg_error;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_read, mem_write, mem_complete;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 = nobody, 1 = core, 2 = debug.
    int m_cur  = 0;   // requester holding an unfinished transfer
    int m_age  = 0;   // ownership cycles already spent by m_cur
    int m_last = 1;   // last requester to finish (round-robin)
    int e_owner;
    bit e_active, e_done, e_timeout;

    mem_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (c_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .core_addr     (core_addr),
        .core_wdata    (core_wdata),
        .core_be       (core_be),
        .core_read     (core_read),
        .core_write    (core_write),
        .core_rdata    (core_rdata),
        .core_complete (core_complete),
        .core_error    (core_error),
        .dbg_addr      (dbg_addr),
        .dbg_wdata     (dbg_wdata),
        .dbg_be        (dbg_be),
        .dbg_read      (dbg_read),
        .dbg_write     (dbg_write),
        .dbg_rdata     (dbg_rdata),
        .dbg_complete  (dbg_complete),
        .dbg_error     (dbg_error),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_rdata     (mem_rdata),
        .mem_complete  (mem_complete)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_core(input bit r, input bit w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b);
        core_read = r; core_write = w; core_addr = a; core_wdata = d; core_be = b;
    endtask

    task automatic set_dbg(input bit r, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b);
        dbg_read = r; dbg_write = w; dbg_addr = a; dbg_wdata = d; dbg_be = b;
    endtask

    task automatic set_mem(input bit c, input logic [31:0] rd);
        mem_complete = c; mem_rdata = rd;
    endtask

    // Evaluate the model for the current inputs and compare every output.
    task automatic settle();
        bit          creq, dreq;
        logic [31:0] x_addr, x_wdata, x_crd, x_drd;
        logic [3:0]  x_be;
        bit          x_rd, x_wr, x_cc, x_ce, x_dc, x_de;
        @(negedge clk);
        creq = core_read || core_write;
        dreq = dbg_read || dbg_write;
        if (m_cur == 0) begin
            if (creq && dreq) begin
`ifdef MEM_ARBITER_RR_EN
                e_owner = (m_last == 1) ? 2 : 1;
`else
                e_owner = 2;
`endif
            end else if (creq) e_owner = 1;
            else if (dreq)     e_owner = 2;
            else               e_owner = 0;
        end else begin
            e_owner = m_cur;
        end
        e_active  = (e_owner == 1 && creq) || (e_owner == 2 && dreq);
        e_timeout = e_active && !mem_complete && (m_age + 1 == c_TIMEOUT);
        e_done    = e_active && (mem_complete || e_timeout);
        x_addr = '0; x_wdata = '0; x_be = '0; x_rd = 0; x_wr = 0;
        x_crd = '0; x_drd = '0; x_cc = 0; x_ce = 0; x_dc = 0; x_de = 0;
        if (rst) begin
            e_done = 0;
        end else if (e_owner == 1) begin
            x_addr = core_addr; x_wdata = core_wdata; x_be = core_be;
            x_rd   = core_read && !core_write && !e_timeout;
            x_wr   = core_write && !e_timeout;
            x_crd  = e_timeout ? 32'h0 : mem_rdata;
            x_cc   = e_done; x_ce = e_timeout;
        end else if (e_owner == 2) begin
            x_addr = dbg_addr; x_wdata = dbg_wdata; x_be = dbg_be;
            x_rd   = dbg_read && !dbg_write && !e_timeout;
            x_wr   = dbg_write && !e_timeout;
            x_drd  = e_timeout ? 32'h0 : mem_rdata;
            x_dc   = e_done; x_de = e_timeout;
        end
        chk("mem_addr", mem_addr, x_addr);
        chk("mem_wdata", mem_wdata, x_wdata);
        chk("mem_be", {28'h0, mem_be}, {28'h0, x_be});
        chk("mem_read", {31'h0, mem_read}, {31'h0, x_rd});
        chk("mem_write", {31'h0, mem_write}, {31'h0, x_wr});
        chk("core_rdata", core_rdata, x_crd);
        chk("core_complete", {31'h0, core_complete}, {31'h0, x_cc});
        chk("core_error", {31'h0, core_error}, {31'h0, x_ce});
        chk("dbg_rdata", dbg_rdata, x_drd);
        chk("dbg_complete", {31'h0, dbg_complete}, {31'h0, x_dc});
        chk("dbg_error", {31'h0, dbg_error}, {31'h0, x_de});
    endtask

    // Advance the model and the clock by one cycle.
    task automatic tick();
        if (rst) begin
            m_cur = 0; m_age = 0; m_last = 1;
        end else if (e_owner == 0 || !e_active || e_done) begin
            if (e_done) m_last = e_owner;
            m_cur = 0; m_age = 0;
        end else begin
            m_cur = e_owner; m_age++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        set_core(0, 0, 32'h0, 32'h0, 4'h0);
        set_dbg(0, 0, 32'h0, 32'h0, 4'h0);
        set_mem(0, 32'h0);
    endtask

    initial begin
        bit          c_act, d_act, c_r, c_w, d_r, d_w;
        logic [31:0] ca, cd, da, dd;
        logic [3:0]  cb, db;

        // Reset with busy inputs: every output must be zero.
        rst = 1'b1;
        set_core(1, 0, 32'h11, 32'h22, 4'hF);
        set_dbg(1, 1, 32'h33, 32'h44, 4'h3);
        set_mem(1, 32'h5555_AAAA);
        settle(); chk("rst_mem_write", {31'h0, mem_write}, 32'h0); tick();
        settle(); tick();
        rst = 1'b0;
        idle_all();
        settle(); tick();

        // Core read at 0x100 completing after 3 wait cycles.
        set_core(1, 0, 32'h100, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            set_mem(0, $urandom);
            settle();
            chk("t1_mem_read", {31'h0, mem_read}, 32'h1);
            chk("t1_mem_addr", mem_addr, 32'h100);
            tick();
        end
        set_mem(1, 32'hDEAD_BEEF);
        settle();
        chk("t1_core_rdata", core_rdata, 32'hDEAD_BEEF);
        chk("t1_core_complete", {31'h0, core_complete}, 32'h1);
        chk("t1_core_error", {31'h0, core_error}, 32'h0);
        tick();
        idle_all(); settle(); tick();

        // Contention with single-cycle memory.
        set_core(1, 0, 32'h200, 32'h0, 4'hF);
        set_dbg(0, 1, 32'h300, 32'hAA, 4'hF);
        set_mem(1, 32'h1234_5678);
        settle();
        chk("t2_dbg_first", {31'h0, dbg_complete}, 32'h1);
        chk("t2_core_waits", {31'h0, core_complete}, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin settle(); tick(); end
        idle_all(); settle(); tick();

        // Debug arrives while the core holds a transfer.
        set_core(1, 0, 32'h400, 32'h0, 4'hF);
        settle(); tick();
        set_dbg(1, 0, 32'h500, 32'h0, 4'hF);
        settle(); chk("t3_dbg_blocked", mem_addr, 32'h400); tick();
        set_mem(1, 32'h0BAD_F00D);
        settle(); chk("t3_core_done", {31'h0, core_complete}, 32'h1); tick();
        set_core(0, 0, 32'h0, 32'h0, 4'h0);
        set_mem(0, 32'h0);
        settle(); chk("t3_dbg_fwd", mem_addr, 32'h500); tick();
        set_mem(1, 32'h77);
        settle(); tick();
        idle_all(); settle(); tick();

        // Memory never completes: watchdog abort on ownership cycle 4.
        set_core(1, 0, 32'h600, 32'h0, 4'hF);
        set_mem(0, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            settle(); chk("t4_no_err", {31'h0, core_error}, 32'h0); tick();
        end
        settle();
        chk("t4_complete", {31'h0, core_complete}, 32'h1);
        chk("t4_error", {31'h0, core_error}, 32'h1);
        chk("t4_rdata", core_rdata, 32'h0);
        chk("t4_strobe", {31'h0, mem_read}, 32'h0);
        tick();
        idle_all(); settle(); tick();

        // Debug read+write together is a write.
        set_dbg(1, 1, 32'h700, 32'h55, 4'b0011);
        set_mem(1, 32'h0);
        settle();
        chk("t5_write", {31'h0, mem_write}, 32'h1);
        chk("t5_read", {31'h0, mem_read}, 32'h0);
        chk("t5_be", {28'h0, mem_be}, 32'h3);
        tick();
        idle_all(); settle(); tick();

        // Reset while debug owns a waiting transfer.
        set_dbg(1, 0, 32'h800, 32'h0, 4'hF);
        settle(); tick();
        rst = 1'b1;
        set_core(1, 0, 32'h900, 32'h0, 4'hF);
        settle(); chk("t6_rst_read", {31'h0, mem_read}, 32'h0); tick();
        rst = 1'b0;
        set_dbg(0, 0, 32'h0, 32'h0, 4'h0);
        settle();
        chk("t6_core_addr", mem_addr, 32'h900);
        chk("t6_core_read", {31'h0, mem_read}, 32'h1);
        tick();
        set_mem(1, 32'h99);
        settle(); tick();
        idle_all(); settle(); tick();

        // Randomized traffic with aborts, timeouts and occasional reset.
        c_act = 0; d_act = 0;
        c_r = 0; c_w = 0; d_r = 0; d_w = 0;
        ca = '0; cd = '0; cb = '0; da = '0; dd = '0; db = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!c_act && $urandom_range(0, 2) == 0) begin
                int k;
                k = $urandom_range(0, 2);
                c_act = 1; c_r = (k != 1); c_w = (k != 0);
                ca = $urandom; cd = $urandom; cb = 4'($urandom);
            end else if (c_act && $urandom_range(0, 39) == 0) begin
                c_act = 0;
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                int k;
                k = $urandom_range(0, 2);
                d_act = 1; d_r = (k != 1); d_w = (k != 0);
                da = $urandom; dd = $urandom; db = 4'($urandom);
            end else if (d_act && $urandom_range(0, 39) == 0) begin
                d_act = 0;
            end
            set_core(c_act && c_r, c_act && c_w, ca, cd, cb);
            set_dbg(d_act && d_r, d_act && d_w, da, dd, db);
            set_mem($urandom_range(0, 2) == 0, $urandom);
            rst = ($urandom_range(0, 199) == 0);
            settle();
            if (e_done && e_owner == 1) c_act = 0;
            if (e_done && e_owner == 2) d_act = 0;
            tick();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
